// File: rtl/button_repeat_conditioner_pkg.sv
// Shared constants for button-driven blocks: FSM state encodings and the
// default timing values used by the debounce / auto-repeat conditioner.
package button_repeat_conditioner_pkg;

    // Default timing, in clk cycles.
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_HOLD_CYCLES     = 25000000;
    localparam int DEF_REPEAT_CYCLES   = 10000000;
    localparam int DEF_CNT_W           = 25;

    // FSM state encodings, kept as plain constants so legacy blocks can reuse them.
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] ST_PRESS_DB   = 3'd1;
    localparam logic [STATE_W-1:0] ST_HOLD       = 3'd2;
    localparam logic [STATE_W-1:0] ST_REPEAT     = 3'd3;
    localparam logic [STATE_W-1:0] ST_RELEASE_DB = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Shift the raw level through two flops; both clear on reset.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour, giving a true two-stage shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/button_repeat_conditioner.sv
// Push-button conditioner: synchronizes and debounces a raw button, emits a
// one-cycle pulse on each accepted press, and auto-repeats the pulse while
// the button is held. All outputs come straight from flops.
module button_repeat_conditioner
    import button_repeat_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    input  logic repeat_en,
    output logic clean,
    output logic pulse,
    output logic repeating
);

    // Terminal counts of the shared timer, one per timed phase.
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic               btn_s;
    logic [STATE_W-1:0] state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               clean_q,     clean_d;
    logic               pulse_q,     pulse_d;
    logic               repeating_q, repeating_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (button),
        .q   (btn_s)
    );

    // Next-state, timer and registered-output decode for the press/hold/repeat FSM.
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clean_d     = clean_q;
        pulse_d     = 1'b0;
        repeating_d = repeating_q;

        case (state_q)
            ST_IDLE: begin
                clean_d     = 1'b0;
                repeating_d = 1'b0;
                if (btn_s) begin
                    state_d = ST_PRESS_DB;
                    cnt_d   = '0;
                end
            end

            ST_PRESS_DB: begin
                if (!btn_s) begin
                    // Bounce: drop back without ever asserting clean or pulse.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_HOLD: begin
                repeating_d = 1'b0;
                if (!btn_s) begin
                    state_d = ST_RELEASE_DB;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    // Timer parks here until repeat is enabled.
                    if (repeat_en) begin
                        state_d     = ST_REPEAT;
                        cnt_d       = '0;
                        pulse_d     = 1'b1;
                        repeating_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_REPEAT: begin
                if (!btn_s) begin
                    state_d     = ST_RELEASE_DB;
                    cnt_d       = '0;
                    repeating_d = 1'b0;
                end else if (!repeat_en) begin
                    // Park in HOLD with the timer already expired: no more pulses
                    // until repeat is re-enabled.
                    state_d     = ST_HOLD;
                    cnt_d       = HOLD_LAST;
                    repeating_d = 1'b0;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_RELEASE_DB: begin
                clean_d = 1'b1;
                if (btn_s) begin
                    // Release bounce: treat as still held, restart the hold timer.
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                clean_d     = 1'b0;
                repeating_d = 1'b0;
            end
        endcase
    end

    // State, timer and output registers; reset forces everything idle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            clean_q     <= 1'b0;
            pulse_q     <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clean_q     <= clean_d;
            pulse_q     <= pulse_d;
            repeating_q <= repeating_d;
        end
    end

    assign clean     = clean_q;
    assign pulse     = pulse_q;
    assign repeating = repeating_q;

endmodule

// File: tb/tb_button_repeat_conditioner.sv
// Self-checking bench for button_repeat_conditioner with short timing
// (debounce 4, hold 10, repeat 3). The stimulus process pushes the edge
// numbers at which pulses are due; a monitor pops one per observed pulse.
module tb_button_repeat_conditioner;

    logic clk;
    logic rst;
    logic button;
    logic repeat_en;
    logic clean;
    logic pulse;
    logic repeating;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int exp_q[$];
    logic prev_pulse = 1'b0;

    button_repeat_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (3),
        .CNT_W           (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .button    (button),
        .repeat_en (repeat_en),
        .clean     (clean),
        .pulse     (pulse),
        .repeating (repeating)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: after rising edge e, edge_n == e.
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d want %0d", name, edge_n, actual, expected);
        end
    endtask

    // Advance to the falling edge that follows rising edge e.
    task automatic wait_to(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    // Pulse monitor: every observed pulse must match the next scheduled edge.
    always @(negedge clk) begin
        if (pulse) begin
            check("pulse_back_to_back", int'(prev_pulse), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pulse_unexpected at edge %0d: got pulse 1 want 0", edge_n);
            end else begin
                check("pulse_edge", edge_n, exp_q.pop_front());
            end
        end
        prev_pulse = pulse;
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int b;
        int k;

        rst       = 1'b0;
        button    = 1'b0;
        repeat_en = 1'b1;

        // Reset state.
        @(posedge clk);
        #1;
        check("rst_clean", int'(clean), 0);
        check("rst_pulse", int'(pulse), 0);
        check("rst_repeating", int'(repeating), 0);
        wait_to(2);
        rst = 1'b1;

        // Clean press sampled at edge 10, held with repeat enabled.
        wait_to(9);
        button = 1'b1;
        exp_q.push_back(16);
        exp_q.push_back(26);
        exp_q.push_back(29);
        exp_q.push_back(32);
        exp_q.push_back(35);
        wait_to(15);
        check("t1_clean_before", int'(clean), 0);
        wait_to(16);
        check("t1_clean_press", int'(clean), 1);
        check("t1_rep_hold", int'(repeating), 0);
        wait_to(25);
        check("t1_rep_before", int'(repeating), 0);
        wait_to(26);
        check("t1_rep_start", int'(repeating), 1);
        wait_to(35);
        button = 1'b0;               // first low sample at edge 36
        wait_to(37);
        check("t1_rep_still", int'(repeating), 1);
        wait_to(38);
        check("t1_rep_release", int'(repeating), 0);
        wait_to(41);
        check("t1_clean_hold", int'(clean), 1);
        wait_to(42);
        check("t1_clean_fall", int'(clean), 0);
        wait_to(45);
        check("t1_pending", exp_q.size(), 0);

        // Press bounce: high 2, low 1, high 2, then low. No pulse, clean stays 0.
        b = edge_n;
        button = 1'b1;
        wait_to(b + 2);
        button = 1'b0;
        wait_to(b + 3);
        button = 1'b1;
        wait_to(b + 5);
        button = 1'b0;
        for (int e = b + 6; e <= b + 16; e += 2) begin
            wait_to(e);
            check("t2_clean_low", int'(clean), 0);
        end

        // Release bounce: low 2, high 1, then low stable.
        b = edge_n;
        k = b + 1;
        button = 1'b1;
        exp_q.push_back(k + 6);
        wait_to(k + 6);
        check("t3_clean_press", int'(clean), 1);
        wait_to(k + 7);
        button = 1'b0;
        wait_to(k + 9);
        button = 1'b1;
        wait_to(k + 10);
        button = 1'b0;
        wait_to(k + 12);
        check("t3_clean_bounce", int'(clean), 1);
        wait_to(k + 16);
        check("t3_clean_hold", int'(clean), 1);
        wait_to(k + 17);
        check("t3_clean_fall", int'(clean), 0);
        wait_to(k + 20);
        check("t3_pending", exp_q.size(), 0);

        // 40-cycle hold with repeat disabled: one pulse, never repeating.
        repeat_en = 1'b0;
        b = edge_n;
        k = b + 1;
        button = 1'b1;
        exp_q.push_back(k + 6);
        for (int e = k; e <= k + 48; e++) begin
            wait_to(e);
            check("t4_rep_low", int'(repeating), 0);
            if (e == k + 39) button = 1'b0;
            if (e == k + 45) check("t4_clean_hold", int'(clean), 1);
            if (e == k + 46) check("t4_clean_fall", int'(clean), 0);
        end
        check("t4_pending", exp_q.size(), 0);
        repeat_en = 1'b1;

        // Reset pulsed during REPEAT with the button held.
        b = edge_n;
        k = b + 1;
        button = 1'b1;
        exp_q.push_back(k + 6);
        exp_q.push_back(k + 16);
        exp_q.push_back(k + 19);
        exp_q.push_back(k + 22);
        wait_to(k + 23);
        check("t5_rep_before", int'(repeating), 1);
        rst = 1'b0;
        #1;
        check("t5_rst_clean", int'(clean), 0);
        check("t5_rst_pulse", int'(pulse), 0);
        check("t5_rst_repeating", int'(repeating), 0);
        wait_to(k + 24);
        rst = 1'b1;                  // first sample after reset at edge k+25
        exp_q.push_back(k + 31);
        wait_to(k + 30);
        check("t5_clean_before", int'(clean), 0);
        wait_to(k + 32);
        button = 1'b0;               // first low sample at edge k+33
        wait_to(k + 38);
        check("t5_clean_hold", int'(clean), 1);
        wait_to(k + 39);
        check("t5_clean_fall", int'(clean), 0);
        wait_to(k + 42);
        check("t5_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
